// File: rtl/bt_status_tx.sv
// Bluetooth status transmitter: watches the command receiver's song/pause/volume state and
// the player's finish pulse, and sends a 4-byte 8N1 UART status frame whenever they change.
module bt_status_tx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_song_select,
  input  logic        i_pause,
  input  logic [15:0] i_vol,
  input  logic        i_finish,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int unsigned RawClks      = CLK_FREQ / BAUD;
  localparam int unsigned ClksPerBit   = (RawClks < 2) ? 2 : RawClks;
  localparam int unsigned CntW         = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntLast  = CntW'(ClksPerBit - 1);
  localparam logic [7:0]      Header   = 8'hA5;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic            load;

  logic            song_q, pause_q, pending_q, finish_q;
  logic [7:0]      vol_hi_q;
  logic [7:0]      status_q, vol_snap_q, csum_q;
  logic [7:0]      status_now, cur_byte;
  logic            evt, cnt_last;
  logic            tx_q, tx_d;

  // Only the volume high byte is reported, so low-byte changes are not events.
  assign evt = (i_song_select != song_q) | (i_pause != pause_q) |
               (i_vol[15:8] != vol_hi_q) | i_finish;

  assign status_now = {5'b0, finish_q, pause_q, song_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q     <= 1'b0;
      pause_q    <= 1'b0;
      vol_hi_q   <= 8'hFF;
      pending_q  <= 1'b0;
      finish_q   <= 1'b0;
      status_q   <= 8'h00;
      vol_snap_q <= 8'h00;
      csum_q     <= 8'h00;
    end else begin
      if (evt) begin
        song_q   <= i_song_select;
        pause_q  <= i_pause;
        vol_hi_q <= i_vol[15:8];
      end
      // A new event in the LOAD cycle wins over the clear, so it is never lost.
      pending_q <= evt | (pending_q & ~load);
      finish_q  <= i_finish | (finish_q & ~load);
      if (load) begin
        status_q   <= status_now;
        vol_snap_q <= vol_hi_q;
        csum_q     <= Header ^ status_now ^ vol_hi_q;
      end
    end
  end

  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q) state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        cnt_d   = '0;
        bit_d   = 3'd0;
        byte_d  = 2'd0;
        state_d = StStart;
      end
      StStart: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (byte_q == 2'd3) begin
            state_d = StIdle;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = StStart;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cur_byte = Header;
    case (byte_d)
      2'd0:    cur_byte = Header;
      2'd1:    cur_byte = status_q;
      2'd2:    cur_byte = vol_snap_q;
      default: cur_byte = csum_q;
    endcase
  end

  // The line level is computed from the next state so the registered o_tx lines up with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = (state_q == StStop) && (byte_q == 2'd3) && cnt_last;

endmodule

// File: tb/tb_bt_status_tx.sv
// Self-checking bench for bt_status_tx: decodes the UART line and compares each frame
// against frames built from the current song/pause/volume values.
module tb_bt_status_tx;

  localparam int Cpb = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_song_select = 1'b0;
  logic        i_pause = 1'b0;
  logic [15:0] i_vol = 16'hFFFF;
  logic        i_finish = 1'b0;
  logic        o_tx, o_busy, o_frame_done;

  int checks = 0;
  int failures = 0;

  bt_status_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_song_select(i_song_select),
    .i_pause      (i_pause),
    .i_vol        (i_vol),
    .i_finish     (i_finish),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  // Line monitor: UART receiver sampling mid-bit, plus frame start/done timestamps.
  int         cyc = 0;
  bit         act = 0;
  int         mc = 0;
  int         fb = 0;
  int         kb = 0;
  int         busy_seen = 0;
  int         framing_err = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         done_q[$];

  always @(negedge clk) begin
    cyc++;
    if (o_frame_done === 1'b1) done_q.push_back(cyc);
    if (o_busy === 1'b1) busy_seen++;
    if (!rst_n) begin
      act = 0;
      fb  = 0;
    end else if (!act) begin
      if (o_tx === 1'b0) begin
        act = 1;
        mc  = 0;
        if (fb == 0) start_q.push_back(cyc);
      end
    end else begin
      mc++;
      if (mc % Cpb == Cpb / 2) begin
        kb = mc / Cpb;
        if (kb >= 1 && kb <= 8) sh[kb-1] = o_tx;
        else if (kb == 9) begin
          if (o_tx !== 1'b1) framing_err++;
          rx_q.push_back(sh);
          fb  = (fb + 1) % 4;
          act = 0;
        end
      end
    end
  end

  // Reference state: the values the transmitter last reported (or its reset values).
  bit         m_song = 0;
  bit         m_pause = 0;
  logic [7:0] m_hi = 8'hFF;

  task automatic clear_mon();
    rx_q.delete();
    start_q.delete();
    done_q.delete();
    busy_seen = 0;
  endtask

  task automatic drive(input bit s, input bit p, input logic [15:0] v, input bit f,
                       output bit evt, output logic [31:0] exp);
    logic [7:0] st;
    evt = (s != m_song) || (p != m_pause) || (v[15:8] != m_hi) || f;
    st  = {5'b0, f, p, s};
    exp = {8'hA5, st, v[15:8], 8'hA5 ^ st ^ v[15:8]};
    m_song = s;
    m_pause = p;
    m_hi = v[15:8];
    @(negedge clk);
    i_song_select = s;
    i_pause = p;
    i_vol = v;
    i_finish = f;
    @(negedge clk);
    i_finish = 1'b0;
  endtask

  task automatic get_frame(output logic [31:0] got, output bit ok);
    int n = 0;
    while (rx_q.size() < 4 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    ok  = (rx_q.size() >= 4);
    got = '0;
    if (ok) for (int i = 0; i < 4; i++) got = {got[23:0], rx_q.pop_front()};
    repeat (30) @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tx, o_busy, o_frame_done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_outputs tx/busy/done=%b expected 100", {o_tx, o_busy, o_frame_done});
    end
    repeat (3) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    repeat (2000) @(posedge clk);
    checks++;
    if (start_q.size() != 0 || rx_q.size() != 0 || busy_seen != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL idle_after_reset starts=%0d bytes=%0d busy=%0d dones=%0d expected 0",
               start_q.size(), rx_q.size(), busy_seen, done_q.size());
    end
  endtask

  task automatic test_song();
    bit evt, ok;
    logic [31:0] exp, got;
    clear_mon();
    drive(1, 0, 16'hFFFF, 0, evt, exp);
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA501FF5B) begin
      failures++;
      $display("FAIL song_frame got=%h ok=%0d expected a501ff5b", got, ok);
    end
    checks++;
    if (done_q.size() != 1 || start_q.size() != 1 || done_q[0] - start_q[0] != 40 * Cpb - 1)
      begin
      failures++;
      $display("FAIL song_timing dones=%0d starts=%0d expected 1 done at start+%0d",
               done_q.size(), start_q.size(), 40 * Cpb - 1);
    end
  endtask

  task automatic test_pause_finish();
    bit evt, ok;
    logic [31:0] exp, got;
    drive(0, 1, 16'hFFFF, 0, evt, exp);
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA502FF58) begin
      failures++;
      $display("FAIL pause_frame got=%h ok=%0d expected a502ff58", got, ok);
    end
    drive(0, 0, 16'hFFFF, 1, evt, exp);
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA504FF5E) begin
      failures++;
      $display("FAIL finish_frame got=%h ok=%0d expected a504ff5e", got, ok);
    end
    drive(1, 0, 16'hFFFF, 0, evt, exp);
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA501FF5B) begin
      failures++;
      $display("FAIL finish_cleared got=%h ok=%0d expected a501ff5b", got, ok);
    end
  endtask

  task automatic test_vol();
    bit evt, ok;
    logic [31:0] exp, got;
    clear_mon();
    drive(1, 0, 16'hFFEF, 0, evt, exp);
    repeat (800) @(posedge clk);
    checks++;
    if (start_q.size() != 0 || busy_seen != 0) begin
      failures++;
      $display("FAIL vol_low_only starts=%0d busy=%0d expected 0", start_q.size(), busy_seen);
    end
    drive(0, 0, 16'hF010, 0, evt, exp);
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA500F055) begin
      failures++;
      $display("FAIL vol_frame got=%h ok=%0d expected a500f055", got, ok);
    end
  endtask

  task automatic test_back_to_back();
    bit evt, ok;
    logic [31:0] exp, got;
    clear_mon();
    drive(0, 0, 16'hFFFF, 0, evt, exp);
    repeat (100) @(posedge clk);
    drive(1, 0, 16'hFFFF, 0, evt, exp);
    repeat (50) @(posedge clk);
    drive(1, 1, 16'hFFFF, 0, evt, exp);
    repeat (50) @(posedge clk);
    drive(1, 1, 16'hF010, 0, evt, exp);
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA500FF5A) begin
      failures++;
      $display("FAIL inflight_frame got=%h ok=%0d expected a500ff5a", got, ok);
    end
    get_frame(got, ok);
    checks++;
    if (!ok || got !== 32'hA503F056) begin
      failures++;
      $display("FAIL coalesced_frame got=%h ok=%0d expected a503f056", got, ok);
    end
    repeat (700) @(posedge clk);
    checks++;
    if (start_q.size() != 2 || done_q.size() != 2 || start_q[1] - done_q[0] != 3) begin
      failures++;
      $display("FAIL coalesce_gap starts=%0d dones=%0d expected 2 frames, gap 3",
               start_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit evt;
    logic [31:0] exp;
    int n = 0;
    int target;
    clear_mon();
    drive(0, 0, 16'hFFFF, 0, evt, exp);
    while (start_q.size() == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    target = (start_q.size() > 0) ? start_q[0] + 2 * 10 * Cpb + 5 * Cpb + Cpb / 2 : cyc;
    n = 0;
    while (cyc < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe_busy busy=%b expected 1", o_busy);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tx, o_busy, o_frame_done} !== 3'b100) begin
      failures++;
      $display("FAIL midframe_reset tx/busy/done=%b expected 100", {o_tx, o_busy, o_frame_done});
    end
    repeat (3) @(negedge clk);
    clear_mon();
    m_song = 0;
    m_pause = 0;
    m_hi = 8'hFF;
    rst_n = 1'b1;
    repeat (2000) @(posedge clk);
    checks++;
    if (start_q.size() != 0 || busy_seen != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL no_resume starts=%0d busy=%0d dones=%0d expected 0",
               start_q.size(), busy_seen, done_q.size());
    end
  endtask

  task automatic test_random();
    bit evt, ok, s, p, f;
    logic [15:0] v;
    logic [31:0] exp, got;
    for (int it = 0; it < 10; it++) begin
      clear_mon();
      s = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       v = {m_hi, 8'($urandom)};
        1:       v = 16'($urandom);
        default: v = {m_hi, 8'h00};
      endcase
      drive(s, p, v, f, evt, exp);
      if (evt) begin
        get_frame(got, ok);
        checks++;
        if (!ok || got !== exp || done_q.size() != 1) begin
          failures++;
          $display("FAIL random_frame[%0d] got=%h ok=%0d dones=%0d expected %h and 1 done",
                   it, got, ok, done_q.size(), exp);
        end
      end else begin
        repeat (800) @(posedge clk);
        checks++;
        if (start_q.size() != 0 || busy_seen != 0) begin
          failures++;
          $display("FAIL random_quiet[%0d] starts=%0d busy=%0d expected 0",
                   it, start_q.size(), busy_seen);
        end
      end
    end
    checks++;
    if (framing_err != 0) begin
      failures++;
      $display("FAIL stop_bits framing_errors=%0d expected 0", framing_err);
    end
  endtask

  initial begin
    test_reset();
    test_song();
    test_pause_finish();
    test_vol();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
